data_cache: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache for the M-stage memory path.
- Replaces the fixed 1 KiB byte-array data memory, whose stall output is tied to 0.
- Adds real miss handling with a backing-memory handshake, a genuine stall, and sub-word access sizes with sign/zero extension.
- Adds flush, misalignment detection and hit/miss counters. Storage is big-endian: byte offset 0 is the MSB.

---
 rtl/data_cache_if.sv | 42 ++++
 rtl/data_cache.sv | 188 ++++++++++++++++++
 tb/tb_data_cache.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Data cache port bundle: CPU-side load/store request and response,
// plus the backing-memory request/ack bus.
interface data_cache_if #(
    parameter int ADDR_BITS  = 32,
    parameter int LINE_BYTES = 16
);
    logic [ADDR_BITS-1:0]    addr;
    logic [63:0]             data_in;
    logic                    rd_en;
    logic                    wr_en;
    logic [1:0]              size;
    logic                    sign_ext;
    logic                    flush;
    logic [63:0]             data_out;
    logic                    stall;
    logic                    misalign;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_BITS-1:0]    mem_addr;
    logic [63:0]             mem_wdata;
    logic [7:0]              mem_wstrb;
    logic [LINE_BYTES*8-1:0] mem_rdata;
    logic                    mem_ack;
    logic [31:0]             hit_count;
    logic [31:0]             miss_count;

    modport slave (
        input  addr, data_in, rd_en, wr_en, size, sign_ext, flush,
        input  mem_rdata, mem_ack,
        output data_out, stall, misalign,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output hit_count, miss_count
    );

    modport master (
        output addr, data_in, rd_en, wr_en, size, sign_ext, flush,
        output mem_rdata, mem_ack,
        input  data_out, stall, misalign,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Big-endian line storage: byte offset 0 sits in the line MSBs.
module data_cache #(
    parameter int ADDR_BITS  = 32,
    parameter int LINES      = 16,
    parameter int LINE_BYTES = 16
) (
    input logic         clk,
    input logic         reset,
    data_cache_if.slave bus
);
    localparam int OFF_BITS = $clog2(LINE_BYTES);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_BITS - OFF_BITS - IDX_BITS;
    localparam int LINE_W   = LINE_BYTES * 8;
    localparam int DWORDS   = LINE_BYTES / 8;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];
    logic [31:0]         hit_q, miss_q;

    logic [OFF_BITS-1:0] offset;
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic [2:0]          lane;

    assign offset = bus.addr[OFF_BITS-1:0];
    assign idx    = bus.addr[OFF_BITS +: IDX_BITS];
    assign tag    = bus.addr[ADDR_BITS-1 -: TAG_BITS];
    assign lane   = bus.addr[2:0];

    logic [3:0] nbytes;
    logic [2:0] amask;
    logic       req, mis, hit, load_ok;

    assign nbytes  = 4'd1 << bus.size;
    assign amask   = 3'(nbytes - 4'd1);
    assign req     = bus.rd_en | bus.wr_en;
    assign mis     = req & (|(lane & amask));
    assign hit     = valid_q[idx] & (tag_q[idx] == tag);
    assign load_ok = (state_q == IDLE) & ~bus.flush & bus.rd_en
                   & ~bus.wr_en & ~mis;

    // Right shift that brings the addressed field down to bit 0
    logic [6:0] sh;
    assign sh = 7'd64 - {1'b0, lane, 3'b000} - {nbytes, 3'b000};

    logic [63:0] dw, raw, ld_val, fmask, wdata;
    logic [7:0]  sbase, wstrb;

    always_comb begin
        dw = '0;
        for (int k = 0; k < DWORDS; k++) begin
            if ((int'(offset) >> 3) == k)
                dw = data_q[idx][LINE_W-1-64*k -: 64];
        end
    end

    assign raw = dw >> sh;

    always_comb begin
        ld_val = raw;
        fmask  = '1;
        sbase  = 8'hFF;
        unique case (bus.size)
            2'd0: begin
                ld_val = {{56{bus.sign_ext & raw[7]}}, raw[7:0]};
                fmask  = 64'hFF;
                sbase  = 8'h01;
            end
            2'd1: begin
                ld_val = {{48{bus.sign_ext & raw[15]}}, raw[15:0]};
                fmask  = 64'hFFFF;
                sbase  = 8'h03;
            end
            2'd2: begin
                ld_val = {{32{bus.sign_ext & raw[31]}}, raw[31:0]};
                fmask  = 64'hFFFF_FFFF;
                sbase  = 8'h0F;
            end
            2'd3: begin
                ld_val = raw;
                fmask  = '1;
                sbase  = 8'hFF;
            end
        endcase
    end

    assign wstrb = sbase << (4'd8 - {1'b0, lane} - nbytes);
    assign wdata = (bus.data_in & fmask) << sh;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.flush && req && !mis) begin
                    if (bus.wr_en)  state_d = WRITE;
                    else if (!hit)  state_d = FILL;
                end
            end
            FILL:    if (bus.mem_ack) state_d = IDLE;
            WRITE:   if (bus.mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.stall     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.data_out  = '0;
        unique case (state_q)
            IDLE: begin
                // A flush wins the cycle; the request replays next cycle
                if (bus.flush) begin
                    bus.stall = req;
                end else if (req && !mis) begin
                    if (bus.wr_en)   bus.stall    = 1'b1;
                    else if (hit)    bus.data_out = ld_val;
                    else             bus.stall    = 1'b1;
                end
            end
            FILL: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {bus.addr[ADDR_BITS-1:OFF_BITS],
                                {OFF_BITS{1'b0}}};
            end
            WRITE: begin
                bus.stall     = ~bus.mem_ack;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {bus.addr[ADDR_BITS-1:3], 3'b000};
                bus.mem_wdata = wdata;
                bus.mem_wstrb = wstrb;
            end
            default: ;
        endcase
    end

    assign bus.misalign   = mis;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            if (state_q == IDLE && bus.flush)
                valid_q <= '0;
            else if (state_q == FILL && bus.mem_ack)
                valid_q[idx] <= 1'b1;
            if (load_ok && hit && hit_q != '1)
                hit_q <= hit_q + 32'd1;
            if (load_ok && !hit && miss_q != '1)
                miss_q <= miss_q + 32'd1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits guard them
    always_ff @(posedge clk) begin
        if (state_q == FILL && bus.mem_ack) begin
            data_q[idx] <= bus.mem_rdata;
            tag_q[idx]  <= tag;
        end else if (state_q == WRITE && bus.mem_ack && hit) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                if ((i / 8) == (int'(offset) / 8) && wstrb[7 - (i % 8)])
                    data_q[idx][LINE_W-1-8*i -: 8] <=
                        wdata[63-8*(i%8) -: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random
// traffic against a line-residency model over a byte-level memory.
module tb_data_cache;
    localparam int AB = 32;
    localparam int LB = 16;
    localparam int LN = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_cache_if #(.ADDR_BITS(AB), .LINE_BYTES(LB)) bus();

    data_cache #(.ADDR_BITS(AB), .LINES(LN), .LINE_BYTES(LB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  bmem [int unsigned];
    bit          mvalid [LN];
    int unsigned mline  [LN];
    int unsigned exp_hit, exp_miss;

    bit          rand_lat = 1'b0;
    int          fixed_lat = 3;
    logic [63:0] last_do, last_wdata;
    logic [7:0]  last_wstrb;

    function automatic logic [7:0] mem_init(int unsigned a);
        return 8'((a * 37) ^ (a >> 4) ^ 32'h5A);
    endfunction

    function automatic logic [7:0] rdb(int unsigned a);
        if (bmem.exists(a)) return bmem[a];
        return mem_init(a);
    endfunction

    function automatic logic [63:0] load_exp(int unsigned a, int sz, bit sx);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int k = 0; k < n; k++) v = {v[55:0], rdb(a + k)};
        if (sx && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("hit_count", 64'(bus.hit_count), 64'(exp_hit));
        chk("miss_count", 64'(bus.miss_count), 64'(exp_miss));
    endtask

    task automatic model_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.addr = '0;
        bus.data_in = '0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.size = 2'd0;
        bus.sign_ext = 1'b0;
        bus.flush = 1'b0;
    endtask

    // Backing memory: acks after a chosen latency, one-cycle pulse
    int  rcnt = 0;
    int  cur_lat = 0;
    bit  busy = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            busy = 1'b0;
        end else if (bus.mem_req) begin
            if (!busy) begin
                busy = 1'b1;
                rcnt = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end
            if (rcnt == cur_lat) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) begin
                    for (int l = 0; l < 8; l++)
                        if (bus.mem_wstrb[7-l])
                            bmem[bus.mem_addr + l] = bus.mem_wdata[63-8*l -: 8];
                end else begin
                    for (int i = 0; i < LB; i++)
                        bus.mem_rdata[LB*8-1-8*i -: 8] = rdb(bus.mem_addr + i);
                end
            end else begin
                rcnt++;
            end
        end else begin
            busy = 1'b0;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        exp_hit = 0;
        exp_miss = 0;
    endtask

    task automatic mis_cycle();
        @(negedge clk);
        chk("mis_flag", 64'(bus.misalign), 64'd1);
        chk("mis_stall", 64'(bus.stall), 64'd0);
        chk("mis_req", 64'(bus.mem_req), 64'd0);
        chk("mis_dout", bus.data_out, 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk_cnt();
    endtask

    task automatic do_read(input int unsigned a, input int sz,
                           input bit sx, input bit fl);
        int unsigned l;
        int ix;
        bit seen;
        l = a / LB;
        ix = int'(l % LN);
        bus.addr = a;
        bus.size = 2'(sz);
        bus.sign_ext = sx;
        bus.rd_en = 1'b1;
        if ((a % (1 << sz)) != 0) begin
            mis_cycle();
            return;
        end
        if (fl) begin
            bus.flush = 1'b1;
            @(negedge clk);
            chk("flush_stall", 64'(bus.stall), 64'd1);
            chk("flush_req", 64'(bus.mem_req), 64'd0);
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
            model_clear();
        end
        if (!(mvalid[ix] && mline[ix] == l)) begin
            exp_miss++;
            @(negedge clk);
            chk("miss_stall", 64'(bus.stall), 64'd1);
            chk("miss_req", 64'(bus.mem_req), 64'd0);
            chk("miss_mis", 64'(bus.misalign), 64'd0);
            @(posedge clk);
            #1;
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                chk("fill_req", 64'(bus.mem_req), 64'd1);
                chk("fill_we", 64'(bus.mem_we), 64'd0);
                chk("fill_addr", 64'(bus.mem_addr), 64'(l * LB));
                chk("fill_stall", 64'(bus.stall), 64'd1);
                if (bus.mem_ack) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!seen) chk("fill_timeout", 64'd0, 64'd1);
            mvalid[ix] = 1'b1;
            mline[ix] = l;
        end
        @(negedge clk);
        chk("hit_stall", 64'(bus.stall), 64'd0);
        chk("hit_req", 64'(bus.mem_req), 64'd0);
        chk("load_data", bus.data_out, load_exp(a, sz, sx));
        last_do = bus.data_out;
        exp_hit++;
        @(posedge clk);
        #1;
        idle_inputs();
        chk_cnt();
    endtask

    task automatic do_write(input int unsigned a, input int sz,
                            input logic [63:0] d);
        int n, p, ln;
        bit seen;
        logic [7:0]  es;
        logic [63:0] ew;
        n = 1 << sz;
        bus.addr = a;
        bus.size = 2'(sz);
        bus.data_in = d;
        bus.wr_en = 1'b1;
        if ((a % n) != 0) begin
            mis_cycle();
            return;
        end
        p = int'(a % 8);
        es = '0;
        ew = '0;
        for (int k = 0; k < n; k++) begin
            ln = p + k;
            es[7-ln] = 1'b1;
            ew[63-8*ln -: 8] = 8'(d >> (8 * (n - 1 - k)));
        end
        @(negedge clk);
        chk("wr_stall0", 64'(bus.stall), 64'd1);
        chk("wr_req0", 64'(bus.mem_req), 64'd0);
        @(posedge clk);
        #1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            chk("wr_req", 64'(bus.mem_req), 64'd1);
            chk("wr_we", 64'(bus.mem_we), 64'd1);
            chk("wr_addr", 64'(bus.mem_addr), 64'(a & ~32'd7));
            chk("wr_wdata", bus.mem_wdata, ew);
            chk("wr_wstrb", 64'(bus.mem_wstrb), 64'(es));
            chk("wr_stall", 64'(bus.stall), 64'(!bus.mem_ack));
            if (bus.mem_ack) begin
                seen = 1'b1;
                last_wdata = bus.mem_wdata;
                last_wstrb = bus.mem_wstrb;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) chk("wr_timeout", 64'd0, 64'd1);
        idle_inputs();
        chk_cnt();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_only_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        model_clear();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned a;
        int sz, r;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        idle_inputs();
        do_reset();

        @(negedge clk);
        chk("rst_dout", bus.data_out, 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_mis", 64'(bus.misalign), 64'd0);
        chk("rst_req", 64'(bus.mem_req), 64'd0);
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        chk_cnt();
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) bmem[32'h40 + i] = 8'(i * 8'h11);
        rand_lat = 1'b0;
        fixed_lat = 3;

        do_read(32'h40, 3, 1'b0, 1'b0);
        chk("t1_dw0", last_do, 64'h0011223344556677);
        do_read(32'h48, 3, 1'b0, 1'b0);
        chk("t1_dw1", last_do, 64'h8899AABBCCDDEEFF);
        chk("t1_hits", 64'(bus.hit_count), 64'd2);
        chk("t1_miss", 64'(bus.miss_count), 64'd1);

        do_read(32'h48, 0, 1'b1, 1'b0);
        chk("t2_sx", last_do, 64'hFFFFFFFFFFFFFF88);
        do_read(32'h48, 0, 1'b0, 1'b0);
        chk("t2_zx", last_do, 64'h88);

        do_write(32'h4A, 1, 64'h1234);
        chk("t3_strb", 64'(last_wstrb), 64'h30);
        chk("t3_wdata", last_wdata, 64'h0000123400000000);
        do_read(32'h48, 3, 1'b0, 1'b0);
        chk("t3_rd", last_do, 64'h88991234CCDDEEFF);
        chk("t3_hits", 64'(bus.hit_count), 64'd5);

        do_write(32'h100, 3, 64'hDEADBEEF_01234567);
        do_read(32'h100, 3, 1'b0, 1'b0);
        chk("t4_rd", last_do, 64'hDEADBEEF_01234567);
        do_read(32'h140, 3, 1'b0, 1'b0);
        do_read(32'h40, 3, 1'b0, 1'b0);
        chk("t4_miss", 64'(bus.miss_count), 64'd4);
        chk("t4_hits", 64'(bus.hit_count), 64'd8);

        do_read(32'h44, 3, 1'b0, 1'b0);
        chk("t5_miss", 64'(bus.miss_count), 64'd4);
        do_flush();
        do_read(32'h40, 3, 1'b0, 1'b0);
        chk("t5_miss2", 64'(bus.miss_count), 64'd5);
        chk("t5_hits2", 64'(bus.hit_count), 64'd9);

        do_reset();
        fixed_lat = 5;
        bus.addr = 32'h40;
        bus.size = 2'd3;
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        exp_hit = 0;
        exp_miss = 0;
        @(negedge clk);
        chk("t6_req", 64'(bus.mem_req), 64'd0);
        chk("t6_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        fixed_lat = 2;
        do_read(32'h40, 3, 1'b0, 1'b0);
        chk("t6_miss", 64'(bus.miss_count), 64'd1);
        chk("t6_hits", 64'(bus.hit_count), 64'd1);

        rand_lat = 1'b1;
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 99));
            sz = int'($urandom_range(0, 3));
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if (r < 55)
                do_read(a, sz, 1'($urandom),
                        ($urandom_range(0, 14) == 0) && (a % (1 << sz) == 0));
            else if (r < 92)
                do_write(a, sz, {$urandom, $urandom});
            else
                do_flush();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
